// File: rtl/l3_req_sequencer_pkg.sv
// Shared encodings for the L3 request sequencer: trace ops, bus ops,
// MESIF line states, snoop results and the sequencer FSM state type.
package l3_pkg;

   // Trace command op codes
   localparam logic [3:0] OP_READ    = 4'd0;
   localparam logic [3:0] OP_WRITE   = 4'd1;
   localparam logic [3:0] OP_IREAD   = 4'd2;
   localparam logic [3:0] OP_SNP_INV = 4'd3;
   localparam logic [3:0] OP_SNP_RD  = 4'd4;
   localparam logic [3:0] OP_SNP_WR  = 4'd5;
   localparam logic [3:0] OP_SNP_RFO = 4'd6;
   localparam logic [3:0] OP_CLEAR   = 4'd8;
   localparam logic [3:0] OP_PRINT   = 4'd9;

   // Bus transaction codes
   localparam logic [2:0] BUS_NONE  = 3'd0;
   localparam logic [2:0] BUS_READ  = 3'd1;
   localparam logic [2:0] BUS_WRITE = 3'd2;
   localparam logic [2:0] BUS_INV   = 3'd3;
   localparam logic [2:0] BUS_RFO   = 3'd4;

   // MESIF line states
   localparam logic [2:0] MESIF_M = 3'd0;
   localparam logic [2:0] MESIF_E = 3'd1;
   localparam logic [2:0] MESIF_S = 3'd2;
   localparam logic [2:0] MESIF_I = 3'd3;
   localparam logic [2:0] MESIF_F = 3'd4;

   // Snoop result codes
   localparam logic [1:0] SNP_HIT   = 2'd0;
   localparam logic [1:0] SNP_HITM  = 2'd1;
   localparam logic [1:0] SNP_NOHIT = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOOKUP  = 3'd1,
      S_WAIT_LK = 3'd2,
      S_EVICT   = 3'd3,
      S_BUSOP   = 3'd4,
      S_UPDATE  = 3'd5,
      S_CLEAR   = 3'd6,
      S_DONE    = 3'd7
   } seq_state_t;

   // Processor-side ops that touch PLRU and statistics
   function automatic logic is_cpu(input logic [3:0] op);
      return (op == OP_READ) || (op == OP_WRITE) || (op == OP_IREAD);
   endfunction

   // Snoop ops observed from other caches
   function automatic logic is_snoop(input logic [3:0] op);
      return (op >= OP_SNP_INV) && (op <= OP_SNP_RFO);
   endfunction

endpackage

// File: rtl/l3_req_sequencer_mesif_next.sv
// MESIF protocol decision: given op, hit, current line state and the bus
// snoop result, produce the next line state, our snoop answer and the bus
// transaction (if any) this command needs. Victim writeback is decided by
// the sequencer, not here.
module l3_mesif_next
   import l3_pkg::*;
(
   input  logic [3:0] op,
   input  logic       hit,
   input  logic [2:0] cur_state,
   input  logic [1:0] bus_snoop,
   output logic [2:0] next_state,
   output logic [1:0] snoop_out,
   output logic       needs_bus,
   output logic [2:0] bus_op
);

   // Protocol table; defaults leave the line untouched with no bus traffic
   always_comb begin
      next_state = cur_state;
      snoop_out  = SNP_NOHIT;
      needs_bus  = 1'b0;
      bus_op     = BUS_NONE;
      case (op)
         OP_READ, OP_IREAD: begin
            if (!hit) begin
               needs_bus  = 1'b1;
               bus_op     = BUS_READ;
               next_state = (bus_snoop == SNP_NOHIT) ? MESIF_E : MESIF_F;
            end
         end
         OP_WRITE: begin
            next_state = MESIF_M;
            if (hit && (cur_state == MESIF_S || cur_state == MESIF_F)) begin
               needs_bus = 1'b1;
               bus_op    = BUS_INV;
            end else if (!hit || cur_state == MESIF_I) begin
               needs_bus = 1'b1;
               bus_op    = BUS_RFO;
            end
         end
         OP_SNP_INV: begin
            if (hit) begin
               snoop_out = SNP_HIT;
               if (cur_state == MESIF_S || cur_state == MESIF_F)
                  next_state = MESIF_I;
            end
         end
         OP_SNP_RD: begin
            if (hit) begin
               next_state = MESIF_S;
               if (cur_state == MESIF_M) begin
                  snoop_out = SNP_HITM;
                  needs_bus = 1'b1;
                  bus_op    = BUS_WRITE;
               end else begin
                  snoop_out = SNP_HIT;
               end
            end
         end
         OP_SNP_WR: begin
            if (hit)
               snoop_out = SNP_HIT;
         end
         OP_SNP_RFO: begin
            if (hit) begin
               next_state = MESIF_I;
               if (cur_state == MESIF_M) begin
                  snoop_out = SNP_HITM;
                  needs_bus = 1'b1;
                  bus_op    = BUS_WRITE;
               end else begin
                  snoop_out = SNP_HIT;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/l3_req_sequencer.sv
// L3 request sequencer: accepts one trace command at a time and walks it
// through lookup, optional victim writeback, bus transaction, line update
// and snoop response, keeping read/write/hit/miss statistics.
module l3_req_sequencer
   import l3_pkg::*;
#(
   parameter int TAG_BITS   = 12,
   parameter int INDEX_BITS = 14,
   parameter int WAY_BITS   = 4,
   parameter int CNT_W      = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_op,
   input  logic [TAG_BITS-1:0]   cmd_tag,
   input  logic [INDEX_BITS-1:0] cmd_index,
   output logic                  lk_req,
   output logic [INDEX_BITS-1:0] lk_index,
   output logic [TAG_BITS-1:0]   lk_tag,
   input  logic                  lk_rsp_valid,
   input  logic                  lk_hit,
   input  logic [WAY_BITS-1:0]   lk_way,
   input  logic [2:0]            lk_state,
   input  logic [WAY_BITS-1:0]   lk_victim_way,
   input  logic [2:0]            lk_victim_state,
   output logic                  upd_valid,
   output logic [INDEX_BITS-1:0] upd_index,
   output logic [WAY_BITS-1:0]   upd_way,
   output logic [TAG_BITS-1:0]   upd_tag,
   output logic [2:0]            upd_state,
   output logic                  upd_plru,
   output logic                  bus_valid,
   output logic [2:0]            bus_op,
   input  logic                  bus_ready,
   input  logic [1:0]            bus_snoop,
   output logic                  snoop_valid,
   output logic [1:0]            snoop_out,
   output logic                  clr_req,
   input  logic                  clr_done,
   output logic                  print_req,
   output logic                  busy,
   output logic [CNT_W-1:0]      cnt_read,
   output logic [CNT_W-1:0]      cnt_write,
   output logic [CNT_W-1:0]      cnt_hit,
   output logic [CNT_W-1:0]      cnt_miss
);

   seq_state_t state, state_nx;

   logic [3:0]            op_q;
   logic [TAG_BITS-1:0]   tag_q;
   logic [INDEX_BITS-1:0] index_q;
   logic                  hit_q;
   logic [2:0]            line_state_q;
   logic [WAY_BITS-1:0]   way_q;
   logic [2:0]            upd_state_q;
   logic [2:0]            bus_op_q;
   logic [1:0]            snoop_out_q;
   logic                  snoop_vld_q;
   logic                  print_q;

   logic       accept;
   logic       lk_done;
   logic       evict_need;
   logic       m_hit;
   logic [2:0] m_cur;
   logic [2:0] m_next;
   logic [1:0] m_snoop;
   logic       m_needs_bus;
   logic [2:0] m_bus_op;

   assign accept  = cmd_valid && (state == S_IDLE);
   assign lk_done = (state == S_WAIT_LK) && lk_rsp_valid;

   // While the lookup answer is arriving, decide from the live response;
   // afterwards (bus phase) use the latched copy.
   assign m_hit = (state == S_WAIT_LK) ? lk_hit   : hit_q;
   assign m_cur = (state == S_WAIT_LK) ? lk_state : line_state_q;

   // A processor miss whose victim is dirty must be written back first
   assign evict_need = !lk_hit && is_cpu(op_q) && (lk_victim_state == MESIF_M);

   l3_mesif_next u_mesif (
      .op         (op_q),
      .hit        (m_hit),
      .cur_state  (m_cur),
      .bus_snoop  (bus_snoop),
      .next_state (m_next),
      .snoop_out  (m_snoop),
      .needs_bus  (m_needs_bus),
      .bus_op     (m_bus_op)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state decision
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_cpu(cmd_op) || is_snoop(cmd_op))
                  state_nx = S_LOOKUP;
               else if (cmd_op == OP_CLEAR)
                  state_nx = S_CLEAR;
            end
         end
         S_LOOKUP:  state_nx = S_WAIT_LK;
         S_WAIT_LK: begin
            if (lk_rsp_valid) begin
               if (is_snoop(op_q)) begin
                  if (!lk_hit)
                     state_nx = S_DONE;
                  else if (m_needs_bus)
                     state_nx = S_BUSOP;
                  else if (m_next != lk_state)
                     state_nx = S_UPDATE;
                  else
                     state_nx = S_DONE;
               end else if (evict_need) begin
                  state_nx = S_EVICT;
               end else if (m_needs_bus) begin
                  state_nx = S_BUSOP;
               end else begin
                  state_nx = S_UPDATE;
               end
            end
         end
         S_EVICT:  if (bus_ready) state_nx = S_BUSOP;
         S_BUSOP:  if (bus_ready) state_nx = S_UPDATE;
         S_UPDATE: state_nx = S_DONE;
         S_CLEAR:  if (clr_done) state_nx = S_IDLE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Command and lookup-result capture (data path, no reset needed)
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= cmd_op;
         tag_q   <= cmd_tag;
         index_q <= cmd_index;
      end
      if (lk_done) begin
         hit_q        <= lk_hit;
         line_state_q <= lk_state;
         way_q        <= lk_hit ? lk_way : lk_victim_way;
         upd_state_q  <= m_next;
         bus_op_q     <= m_bus_op;
         snoop_out_q  <= m_snoop;
      end
      if ((state == S_BUSOP) && bus_ready)
         upd_state_q <= m_next;
   end

   // Control strobes and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         snoop_vld_q <= 1'b0;
         print_q     <= 1'b0;
         cnt_read    <= '0;
         cnt_write   <= '0;
         cnt_hit     <= '0;
         cnt_miss    <= '0;
      end else begin
         snoop_vld_q <= lk_done && is_snoop(op_q);
         print_q     <= accept && (cmd_op == OP_PRINT);
         if ((state == S_CLEAR) && clr_done) begin
            cnt_read  <= '0;
            cnt_write <= '0;
            cnt_hit   <= '0;
            cnt_miss  <= '0;
         end else if (lk_done && is_cpu(op_q)) begin
            if (op_q == OP_WRITE)
               cnt_write <= cnt_write + CNT_W'(1);
            else
               cnt_read <= cnt_read + CNT_W'(1);
            if (lk_hit)
               cnt_hit <= cnt_hit + CNT_W'(1);
            else
               cnt_miss <= cnt_miss + CNT_W'(1);
         end
      end
   end

   // Output decode; data fields are zero except while their strobe is high
   always_comb begin
      cmd_ready   = (state == S_IDLE);
      busy        = (state != S_IDLE);
      lk_req      = (state == S_LOOKUP);
      lk_index    = '0;
      lk_tag      = '0;
      upd_valid   = (state == S_UPDATE);
      upd_index   = '0;
      upd_way     = '0;
      upd_tag     = '0;
      upd_state   = '0;
      upd_plru    = 1'b0;
      bus_valid   = 1'b0;
      bus_op      = BUS_NONE;
      clr_req     = (state == S_CLEAR) && !rst;
      snoop_valid = snoop_vld_q;
      snoop_out   = snoop_vld_q ? snoop_out_q : '0;
      print_req   = print_q;
      if (state == S_LOOKUP) begin
         lk_index = index_q;
         lk_tag   = tag_q;
      end
      if (state == S_UPDATE) begin
         upd_index = index_q;
         upd_way   = way_q;
         upd_tag   = tag_q;
         upd_state = upd_state_q;
         upd_plru  = is_cpu(op_q);
      end
      if (!rst && (state == S_EVICT)) begin
         bus_valid = 1'b1;
         bus_op    = BUS_WRITE;
      end else if (!rst && (state == S_BUSOP)) begin
         bus_valid = 1'b1;
         bus_op    = bus_op_q;
      end
   end

endmodule

// File: doc/l3_req_sequencer.md
Name: l3_req_sequencer

Overview:
Controller that sequences every trace command (ops 0-9) through the L3 cache resources: tag/PLRU lookup, line update, bus transaction and snoop response. It accepts one command at a time and drives the lookup and update ports of the tag/state/PLRU array. It owns the MESIF next-state decision, victim writeback ordering and the hit/miss/read/write statistics. It sits between the trace front end and the cache arrays plus the bus model.

Parameters:
TAG_BITS, 12, tag width
INDEX_BITS, 14, set index width
WAY_BITS, 4, way select width (16 ways)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept (IDLE only)
cmd_op  in  4  trace op 0-9
cmd_tag  in  TAG_BITS  address tag
cmd_index  in  INDEX_BITS  set index
lk_req  out  1  one-cycle lookup strobe; lk_index/lk_tag valid with it
lk_index  out  INDEX_BITS  lookup set
lk_tag  out  TAG_BITS  lookup tag
lk_rsp_valid  in  1  lookup result valid (>=1 cycle after lk_req)
lk_hit  in  1  valid tag match
lk_way  in  WAY_BITS  matching way
lk_state  in  3  MESIF state of matching way
lk_victim_way  in  WAY_BITS  PLRU victim way
lk_victim_state  in  3  MESIF state of victim
upd_valid  out  1  one-cycle line write strobe
upd_index / upd_way / upd_tag  out  INDEX_BITS / WAY_BITS / TAG_BITS  line to write
upd_state  out  3  new MESIF state
upd_plru  out  1  touch PLRU for upd_way
bus_valid  out  1  bus request, held until bus_ready
bus_op  out  3  READ=1 WRITE=2 INVALIDATE=3 RFO=4
bus_ready  in  1  bus accepted; bus_snoop valid in same cycle
bus_snoop  in  2  HIT=0 HITM=1 NOHIT=2 (READ/RFO only)
snoop_valid  out  1  one-cycle snoop response strobe
snoop_out  out  2  HIT/HITM/NOHIT
clr_req  out  1  array clear request, held until clr_done
clr_done  in  1  clear complete
print_req  out  1  one-cycle print strobe (op 9)
busy  out  1  not in IDLE
cnt_read / cnt_write / cnt_hit / cnt_miss  out  CNT_W each  statistics

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; counters 0; FSM to IDLE. Reset mid-operation abandons the command, drops bus_valid/clr_req immediately.
- States: IDLE, LOOKUP, WAIT_LK, EVICT, BUSOP, UPDATE, CLEAR, DONE.
- IDLE: on cmd_valid&&cmd_ready latch op/tag/index. Ops 0-6 -> LOOKUP; op 8 -> CLEAR; op 9 -> print_req pulse next cycle, back to IDLE; ops 7, 10-15 consumed, ignored, back to IDLE.
- LOOKUP: lk_req=1 one cycle -> WAIT_LK. WAIT_LK: hold until lk_rsp_valid; latch all lk_* fields.
- Read (0,2): hit -> cnt_hit++, UPDATE with state unchanged, upd_plru=1. Miss -> cnt_miss++; if victim_state==M -> EVICT (bus WRITE); then BUSOP READ; NOHIT -> E, HIT/HITM -> F; UPDATE victim way with new tag, upd_plru=1. cnt_read++ per command.
- Write (1): hit M/E -> M, no bus. Hit S/F -> BUSOP INVALIDATE then M. Miss -> optional EVICT, BUSOP RFO, -> M. upd_plru=1. cnt_write++, hit/miss as above.
- Snoops (3-6): never touch PLRU or counters. snoop_valid pulses the cycle after lk_rsp_valid. Miss -> NOHIT, no update.
- Snooped read (4): M -> HITM, bus WRITE writeback, -> S. E/S/F -> HIT, -> S.
- Snooped RFO (6): M -> HITM, writeback, -> I. E/S/F -> HIT, -> I.
- Snooped invalidate (3): S/F -> I, HIT. M/E unchanged.
- Snooped write (5): HIT/NOHIT per lookup, no state change.
- Bus handshake: bus_valid/bus_op stable until bus_ready; sample bus_snoop on the ready cycle. bus_valid drops next cycle.
- UPDATE: upd_valid one cycle -> DONE -> IDLE. Minimum read-hit latency is accept to upd_valid = 3 cycles with 1-cycle lookup.
- CLEAR: clr_req held until clr_done; on done, counters -> 0, IDLE.
- MESIF encoding: M=0 E=1 S=2 I=3 F=4. Counters wrap at 2^CNT_W.

Decomposition:
- Package l3_pkg: trace op codes, bus op codes, MESIF codes, snoop result codes.
- Sub-module l3_mesif_next: combinational function of (op, hit, cur_state, bus_snoop) -> next_state, snoop_out, needs_bus, bus_op.

Test Plan:
- Read miss, victim I, bus_snoop=NOHIT -> bus READ, upd_state=E, upd_plru=1, cnt_miss=1, cnt_read=1.
- Write to S hit -> bus INVALIDATE, upd_state=M, cnt_hit=1, cnt_write=1.
- Read miss, victim M -> bus WRITE then bus READ in order; bus_snoop=HIT -> F.
- Snooped read on M line -> snoop_out=HITM, bus WRITE, upd_state=S, no PLRU touch, counters unchanged.
- bus_ready withheld 5 cycles -> bus_op stable and cmd_ready=0 throughout; reset asserted in cycle 3 -> all outputs 0, IDLE.
- Op 8 after traffic -> clr_req held until clr_done; counters 0. Op 9 -> single print_req pulse.
